// File: rtl/accum_line_packer_pkg.sv
// accum_line_packer_pkg: shared line geometry and FSM state type for the accumulator line packer.
package accum_line_packer_pkg;
    localparam int LINE_W         = 512;
    localparam int CPLX_W         = 64;
    localparam int WORDS_PER_LINE = 8;
    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE} state_e;
endpackage

// File: rtl/accum_line_packer_line_fifo.sv
// line_fifo: synchronous show-ahead FIFO; a push into a full FIFO lands only when a pop frees the slot that cycle.
module line_fifo #(
    parameter int WIDTH = 528,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;
    assign full  = count_q == (AW+1)'(DEPTH);
    assign empty = count_q == '0;
    assign count = count_q;
    assign dout  = mem_q[rd_q];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    always_comb begin
        mem_d = mem_q;
        if (do_push) mem_d[wr_q] = din;
        wr_d    = wr_q + AW'(do_push);
        rd_d    = rd_q + AW'(do_pop);
        count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/accum_line_packer.sv
// accum_line_packer: packs accumulator bursts into 512-bit lines, buffers them, and flags overflow/protocol errors.
module accum_line_packer
    import accum_line_packer_pkg::*;
#(
    parameter int BURST_LEN  = 32,
    parameter int FIFO_DEPTH = 8,
    parameter int IDX_W      = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [CPLX_W-1:0]             in,
    input  logic                          in_start,
    output logic [LINE_W-1:0]             line_data,
    output logic                          line_valid,
    input  logic                          line_ready,
    output logic [IDX_W-1:0]              line_idx,
    output logic                          burst_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic                          proto_err
);
    localparam int WC_W = $clog2(BURST_LEN);
    state_e            state_q, state_d;
    logic [WC_W-1:0]   wc_q, wc_d;
    logic [CPLX_W-1:0] lanes_q [WORDS_PER_LINE-1];
    logic [CPLX_W-1:0] lanes_d [WORDS_PER_LINE-1];
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              burst_done_q, burst_done_d;
    logic              overflow_q, overflow_d;
    logic              proto_err_q, proto_err_d;
    logic              capture, last, push, pop, full, empty;
    logic [2:0]        lane;
    logic [LINE_W-1:0] line;
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end
    always_comb begin
        state_d = (state_q == IDLE)  ? (in_start ? ARMED : IDLE) :
                  (state_q == ARMED) ? CAPTURE :
                  last               ? (in_start ? ARMED : IDLE) : CAPTURE;
    end
    // ARMED is the cycle that carries word 0, so capture runs in both ARMED and CAPTURE
    always_comb begin
        capture = state_q != IDLE;
        lane    = wc_q[2:0];
        last    = (state_q == CAPTURE) && (wc_q == WC_W'(BURST_LEN - 1));
        push    = capture && (lane == 3'd7);
    end
    assign line = {in, lanes_q[6], lanes_q[5], lanes_q[4], lanes_q[3], lanes_q[2], lanes_q[1], lanes_q[0]};
    assign pop  = line_valid && line_ready;
    always_comb begin
        lanes_d = lanes_q;
        if (capture && lane != 3'd7) lanes_d[lane] = in;
        wc_d         = capture ? (last ? '0 : wc_q + WC_W'(1)) : '0;
        idx_d        = idx_q + IDX_W'(push);
        burst_done_d = last;
        overflow_d   = overflow_q | (push && full && !pop);
        proto_err_d  = proto_err_q | (in_start && capture && !last);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < WORDS_PER_LINE - 1; i++) lanes_q[i] <= '0;
            wc_q         <= '0;
            idx_q        <= '0;
            burst_done_q <= 1'b0;
            overflow_q   <= 1'b0;
            proto_err_q  <= 1'b0;
        end else begin
            lanes_q      <= lanes_d;
            wc_q         <= wc_d;
            idx_q        <= idx_d;
            burst_done_q <= burst_done_d;
            overflow_q   <= overflow_d;
            proto_err_q  <= proto_err_d;
        end
    end
    line_fifo #(.WIDTH(LINE_W + IDX_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (line_ready),
        .din   ({idx_q, line}),
        .dout  ({line_idx, line_data}),
        .full  (full),
        .empty (empty),
        .count (fifo_count)
    );
    assign line_valid = !empty;
    assign burst_done = burst_done_q;
    assign overflow   = overflow_q;
    assign proto_err  = proto_err_q;
endmodule

// File: tb/tb_accum_line_packer.sv
// tb_accum_line_packer: randomized bursts against a queue-based line model, checked by an independent monitor.
module tb_accum_line_packer;
    localparam int BL = 32, DEPTH = 8, IW = 16;
    logic                     clk = 0, reset = 1, in_start = 0, line_ready = 0;
    logic [63:0]              in = '0;
    logic [511:0]             line_data;
    logic                     line_valid, burst_done, overflow, proto_err;
    logic [IW-1:0]            line_idx;
    logic [$clog2(DEPTH):0]   fifo_count;
    always #5 clk = ~clk;
    accum_line_packer #(.BURST_LEN(BL), .FIFO_DEPTH(DEPTH), .IDX_W(IW)) dut (
        .clk(clk), .reset(reset), .in(in), .in_start(in_start),
        .line_data(line_data), .line_valid(line_valid), .line_ready(line_ready),
        .line_idx(line_idx), .burst_done(burst_done), .fifo_count(fifo_count),
        .overflow(overflow), .proto_err(proto_err)
    );
    int n_chk = 0, n_pass = 0;
    task automatic chk(input string nm, input logic [575:0] act, input logic [575:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask
    // reference: expected FIFO contents as a queue of {idx, line}
    logic [IW+511:0] q[$];
    logic [IW-1:0]   m_idx = '0;
    bit              m_ov = 0, m_pe = 0, m_done = 0, mon_en = 0;
    bit              mdl_push = 0, mdl_last = 0, mdl_proto = 0;
    logic [511:0]    mdl_line = '0;
    always @(posedge clk) begin
        if (reset) begin
            q.delete();
            m_idx = '0; m_ov = 0; m_pe = 0; m_done = 0;
        end else begin
            bit pop;
            pop    = line_ready && q.size() > 0;
            m_done = mdl_last;
            if (mdl_proto) m_pe = 1;
            if (mdl_push) begin
                if (q.size() < DEPTH || pop) q.push_back({m_idx, mdl_line});
                else m_ov = 1;
                m_idx++;
            end
            if (pop) void'(q.pop_front());
        end
    end
    always @(negedge clk) begin
        if (mon_en) begin
            chk("line_valid", line_valid, q.size() > 0);
            chk("fifo_count", fifo_count, q.size());
            chk("overflow", overflow, m_ov);
            chk("proto_err", proto_err, m_pe);
            chk("burst_done", burst_done, m_done);
            if (q.size() > 0) begin
                chk("line_data", line_data, q[0][511:0]);
                chk("line_idx", line_idx, q[0][IW+511:512]);
            end
        end
    end
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic clr();
        in_start = 0; mdl_push = 0; mdl_last = 0; mdl_proto = 0;
    endtask
    task automatic idle(input int k, input int rmode);
        for (int c = 0; c < k; c++) begin
            clr();
            in = {$urandom, $urandom};
            if (rmode == 2) line_ready = 1'($urandom_range(0, 1));
            step();
        end
    endtask
    task automatic reset_checks();
        chk("rst_line_data", line_data, 0);
        chk("rst_line_valid", line_valid, 0);
        chk("rst_line_idx", line_idx, 0);
        chk("rst_burst_done", burst_done, 0);
        chk("rst_fifo_count", fifo_count, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_proto_err", proto_err, 0);
    endtask
    bit chained = 0;
    // rmode: 0 hold ready, 1 ready only on each line's last word, 2 random ready
    task automatic burst(input int proto_at, input int reset_at, input bit chain, input int rmode, input bit seq);
        logic [63:0] w [8];
        if (!chained) begin
            clr();
            in_start = 1;
            if (rmode == 2) line_ready = 1'($urandom_range(0, 1));
            step();
        end
        chained = 0;
        for (int n = 0; n < BL; n++) begin
            in        = seq ? {32'(n), 32'(-n)} : {$urandom, $urandom};
            w[n % 8]  = in;
            in_start  = (n == proto_at) || (chain && n == BL - 1);
            mdl_proto = n == proto_at;
            mdl_push  = n % 8 == 7;
            if (mdl_push) mdl_line = {w[7], w[6], w[5], w[4], w[3], w[2], w[1], w[0]};
            mdl_last  = n == BL - 1;
            reset     = n == reset_at;
            if (rmode == 1) line_ready = n % 8 == 7;
            else if (rmode == 2) line_ready = 1'($urandom_range(0, 1));
            step();
            if (n == reset_at) begin
                reset = 0;
                clr();
                return;
            end
        end
        clr();
        chained = chain;
    endtask
    initial begin
        repeat (3) step();
        reset_checks();
        reset = 0;
        mon_en = 1;
        line_ready = 1;
        idle(5, 0);
        burst(-1, -1, 0, 0, 1);
        idle(3, 0);
        burst(-1, -1, 1, 0, 0);
        burst(-1, -1, 0, 0, 0);
        idle(3, 0);
        line_ready = 0;
        repeat (3) burst(-1, -1, 0, 0, 0);
        idle(4, 0);
        chk("overflow_set", overflow, 1);
        chk("count_saturated", fifo_count, DEPTH);
        line_ready = 1;
        idle(12, 0);
        reset = 1;
        step();
        reset = 0;
        line_ready = 0;
        repeat (2) burst(-1, -1, 0, 0, 0);
        burst(-1, -1, 0, 1, 0);
        chk("full_pop_no_overflow", overflow, 0);
        chk("full_pop_count", fifo_count, DEPTH);
        line_ready = 1;
        idle(12, 0);
        burst(9, -1, 0, 0, 0);
        burst(0, -1, 0, 0, 0);
        idle(5, 0);
        burst(-1, 9, 0, 0, 0);
        reset_checks();
        idle(6, 0);
        burst(-1, -1, 0, 0, 0);
        idle(3, 0);
        for (int r = 0; r < 14; r++) begin
            burst(($urandom_range(0, 5) == 0) ? int'($urandom_range(0, BL - 2)) : -1, -1,
                  1'($urandom_range(0, 1)), 2, 0);
            if (!chained) idle($urandom_range(0, 4), 2);
        end
        line_ready = 1;
        idle(20, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/accum_line_packer.md
Name: accum_line_packer

Overview:
- Sits directly downstream of the complex accumulator in the FFT conv-layer datapath.
- Captures each burst of accumulated complex results, which the accumulator announces one cycle early with a single-cycle valid pulse.
- Packs 8 complex_t words into one 512-bit cache line and buffers lines in a FIFO.
- Presents lines to the AFU write engine over a valid/ready handshake. The accumulator cannot be stalled, so buffer overflow is detected and flagged, never back-pressured.

Parameters:
- BURST_LEN, 32: complex words per start pulse; must be a multiple of 8 and at least 8.
- FIFO_DEPTH, 8: line FIFO depth in lines; power of 2.
- IDX_W, 16: width of the line index tag; wraps modulo 2^IDX_W.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- in  in  complex_t (64)  accumulator result word
- in_start  in  1  accumulator output_valid; data is valid on the BURST_LEN consecutive cycles starting the next cycle
- line_data  out  512  packed line; word k occupies bits [64k+63:64k], with r in [63:32] and i in [31:0]
- line_valid  out  1  FIFO head is valid
- line_ready  in  1  consumer accepts the head when line_valid && line_ready
- line_idx  out  IDX_W  sequence number of the line at the FIFO head
- burst_done  out  1  one-cycle pulse after the last word of a burst is captured
- fifo_count  out  $clog2(FIFO_DEPTH)+1  lines currently buffered
- overflow  out  1  sticky: a completed line was dropped because the FIFO was full
- proto_err  out  1  sticky: in_start arrived mid-burst

Behaviour:
- Reset: all outputs 0; FSM to IDLE; word and line counters 0; FIFO emptied; partial line discarded; sticky flags cleared. A reset mid-burst abandons the burst, and later words are ignored until the next in_start.
- States and transitions:
  - IDLE -> ARMED on in_start.
  - ARMED -> CAPTURE on the next cycle; the word on `in` that cycle is word 0.
  - CAPTURE captures one word per cycle, with word counter wc running 0..BURST_LEN-1.
  - At wc = BURST_LEN-1: go to IDLE, or to ARMED if in_start is high the same cycle. Back-to-back bursts are legal with no gap.
- in_start handling:
  - in_start in ARMED, or in CAPTURE with wc < BURST_LEN-1: ignored, proto_err set, current burst continues unchanged.
  - in_start while in IDLE is the normal case.
- Packing:
  - Words with lane = wc mod 8 equal to 0..6 are held in a 7-entry lane register.
  - On lane 7, the full line {in, lanes6..0} is written to the FIFO at that same edge.
  - The line becomes visible (line_valid=1) the following cycle if the FIFO was empty. Latency from word 7 sampled to line_valid is 1 cycle.
- Line index: a counter increments on every line write attempt, including dropped lines, and is stored alongside each line. line_idx is the stored tag of the head. A dropped line leaves a visible gap in line_idx.
- Full FIFO: if the FIFO is full and no pop happens the same cycle, the line is dropped and overflow is set. A simultaneous pop and push on a full FIFO is legal and loses nothing.
- Empty FIFO: line_valid=0; line_data holds its last value (don't-care).
- Simultaneous push and pop on an empty FIFO: the push lands, the pop is not possible since line_valid=0.
- Handshake: line_data and line_idx are stable while line_valid && !line_ready.
- fifo_count: reflects pushes and pops one cycle after the edge at which they occur.
- burst_done: high the cycle after wc = BURST_LEN-1 is sampled; asserted even if that burst's final line was dropped.
- Arithmetic: no arithmetic on data; words pass bit-exact.

Decomposition:
- Shared package: constants LINE_W=512, CPLX_W=64 and WORDS_PER_LINE=8. complex_t stays in common.vh.
- Sub-module line_fifo: synchronous FIFO parameterized by WIDTH=LINE_W+IDX_W and DEPTH, with push, pop, full, empty and count ports, and show-ahead head.

Test Plan:
- Single burst: in_start at cycle 10, words 0..31 with r=n, i=-n on cycles 11..42, line_ready=1 -> 4 lines with line_idx 0..3; line 0 bits [63:32]=0 and [575-64:512-64] r=7; line_valid first high at cycle 19; burst_done high at cycle 43.
- Back-to-back: second in_start on cycle 42 (last word of burst 1) -> burst 2 captured cycles 43..74, no proto_err, 8 lines idx 0..7 in order.
- Back-pressure/overflow: line_ready=0, FIFO_DEPTH=8, three bursts -> fifo_count saturates at 8; lines idx 8..11 dropped; overflow=1; then ready=1 drains idx 0..7.
- Full with simultaneous pop: FIFO full, line_ready=1 on the cycle the 9th line completes -> no drop, overflow stays 0, count stays 8.
- Protocol error: in_start at cycle 10 and again at cycle 20 -> proto_err=1 from cycle 21; exactly 4 lines produced, matching the cycle 10 burst.
- Reset mid-burst: reset at cycle 20 during a burst -> all outputs 0 on cycle 21; no line emitted from the partial burst; a new in_start then yields line_idx starting at 0.
